// File: rtl/i2c_byte_master.sv
// I2C master byte engine: optional (repeated) START, eight data bits MSB first,
// slave ACK sample, optional STOP. Line drives are open-drain style (0 = pull low, 1 = release).
module i2c_byte_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic [7:0] tx_data,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       done,
  output logic       ack_n
);

  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    data_q, data_d;
  logic          stop_q, stop_d;
  logic [DW-1:0] div_q, div_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          sync1_q, sync2_q;
  logic          accept;
  logic          tick;

  assign accept    = cmd_valid & ready_q;
  assign tick      = (state_q != IDLE) && (div_q == DW'(CLK_DIV - 1));
  assign cmd_ready = ready_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;
  assign done      = done_q;
  assign ack_n     = ack_q;

  // Line values are computed for the quarter being entered, so they change only on
  // an accept or a tick and always come straight out of a flop.
  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bitCnt_d  = bitCnt_q;
    data_d    = data_q;
    stop_d    = stop_q;
    div_d     = div_q;
    scl_d     = scl_q;
    sda_d     = sda_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    if (accept) begin
      data_d    = tx_data;
      stop_d    = cmd_stop;
      div_d     = '0;
      quarter_d = 2'd0;
      bitCnt_d  = 3'd7;
      ready_d   = 1'b0;
      state_d   = cmd_start ? START : BIT;
    end else if (state_q != IDLE) begin
      if (tick) begin
        div_d     = '0;
        quarter_d = quarter_q + 2'd1;
        if (state_q == ACK && quarter_q == 2'd2) ack_d = sync2_q;
        if (quarter_q == 2'd3) begin
          case (state_q)
            START: state_d = BIT;
            BIT: begin
              if (bitCnt_q == 3'd0) state_d = ACK;
              else bitCnt_d = bitCnt_q - 3'd1;
            end
            ACK:     state_d = stop_q ? STOP : IDLE;
            default: state_d = IDLE;
          endcase
          if (state_d == IDLE) begin
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    if (accept || tick) begin
      case (state_d)
        START: begin
          case (quarter_d)
            2'd0: sda_d = 1'b1;
            2'd1: begin scl_d = 1'b1; sda_d = 1'b1; end
            2'd2: begin scl_d = 1'b1; sda_d = 1'b0; end
            default: begin scl_d = 1'b0; sda_d = 1'b0; end
          endcase
        end
        BIT: begin
          scl_d = quarter_d[0] ^ quarter_d[1];
          sda_d = data_d[bitCnt_d];
        end
        ACK: begin
          scl_d = quarter_d[0] ^ quarter_d[1];
          sda_d = 1'b1;
        end
        STOP: begin
          case (quarter_d)
            2'd0: begin scl_d = 1'b0; sda_d = 1'b0; end
            2'd1: begin scl_d = 1'b1; sda_d = 1'b0; end
            default: begin scl_d = 1'b1; sda_d = 1'b1; end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      quarter_q <= 2'd0;
      bitCnt_q  <= 3'd7;
      data_q    <= 8'h00;
      stop_q    <= 1'b0;
      div_q     <= '0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ack_q     <= 1'b1;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bitCnt_q  <= bitCnt_d;
      data_q    <= data_d;
      stop_q    <= stop_d;
      div_q     <= div_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      sync1_q   <= sda_i;
      sync2_q   <= sync1_q;
    end
  end

endmodule
